// File: rtl/lfsr_checker.sv
// Receive-side checker for the 10-bit XNOR LFSR pattern generator.
// Self-synchronises a shadow LFSR from the incoming bit stream, then
// flywheels it to predict and check each following bit. Reports lock
// status, per-bit error pulses and saturating bit/error counters.
module lfsr_checker #(
   parameter int LOCK_COUNT  = 16,
   parameter int UNLOCK_ERRS = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int CERR_W  = $clog2(UNLOCK_ERRS + 1);

   localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [CERR_W-1:0]  CERR_ONE   = CERR_W'(1);
   localparam logic [CERR_W-1:0]  CERR_LAST  = CERR_W'(UNLOCK_ERRS - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [3:0]         FILL_FULL  = 4'd10;
   localparam logic [9:0]         LOCKUP     = 10'h3FF;

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t             state_q,     state_d;
   logic [9:0]         sh_q,        sh_d;
   logic [3:0]         fill_q,      fill_d;
   logic [MATCH_W-1:0] match_q,     match_d;
   logic [CERR_W-1:0]  cerr_q,      cerr_d;
   logic               locked_q,    locked_d;
   logic               bit_err_q,   bit_err_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [CNT_W-1:0]   bit_count_q, bit_count_d;
   logic               pred;

   // Counters stick at all-ones once saturated.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   assign pred = ~(sh_q[6] ^ sh_q[9]);

   // Next-state: hunt/fill/match while unlocked, flywheel and check while locked.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      fill_d      = fill_q;
      match_d     = match_q;
      cerr_d      = cerr_q;
      locked_d    = locked_q;
      bit_err_d   = 1'b0;
      err_count_d = err_count_q;
      bit_count_d = bit_count_q;

      if (in_valid) begin
         if (state_q == HUNT) begin
            sh_d = {sh_q[8:0], in_bit};
            if (fill_q < FILL_FULL) begin
               fill_d  = fill_q + 4'd1;
               match_d = '0;
            end else if (in_bit == pred) begin
               if (match_q == MATCH_LAST) begin
                  // The all-ones lockup state predicts itself forever; never lock on it.
                  if (sh_d != LOCKUP) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     match_d  = '0;
                     cerr_d   = '0;
                  end
               end else begin
                  match_d = match_q + MATCH_ONE;
               end
            end else begin
               match_d = '0;
            end
         end else begin
            sh_d        = {sh_q[8:0], pred};
            bit_count_d = sat_inc(bit_count_q);
            bit_err_d   = (in_bit != pred);
            if (in_bit != pred) begin
               err_count_d = sat_inc(err_count_q);
               if (cerr_q == CERR_LAST) begin
                  state_d  = HUNT;
                  locked_d = 1'b0;
                  fill_d   = '0;
                  match_d  = '0;
                  cerr_d   = '0;
               end else begin
                  cerr_d = cerr_q + CERR_ONE;
               end
            end else begin
               cerr_d = '0;
            end
         end
      end

      if (clear_cnt) begin
         err_count_d = '0;
         bit_count_d = '0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= HUNT;
         sh_q        <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         cerr_q      <= '0;
         locked_q    <= 1'b0;
         bit_err_q   <= 1'b0;
         err_count_q <= '0;
         bit_count_q <= '0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         cerr_q      <= cerr_d;
         locked_q    <= locked_d;
         bit_err_q   <= bit_err_d;
         err_count_q <= err_count_d;
         bit_count_q <= bit_count_d;
      end
   end

   assign locked    = locked_q;
   assign bit_err   = bit_err_q;
   assign err_count = err_count_q;
   assign bit_count = bit_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed testbench for lfsr_checker: a default instance (CNT_W=16) and a
// narrow-counter instance (CNT_W=4) share the same stimulus.
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        clear_cnt = 1'b0;
   logic        locked, bit_err;
   logic [15:0] err_count, bit_count;
   logic        locked4, bit_err4;
   logic [3:0]  err_count4, bit_count4;

   int          total = 0;
   int          bad = 0;
   logic [9:0]  g = '0;

   lfsr_checker dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .clear_cnt(clear_cnt), .locked(locked), .bit_err(bit_err),
      .err_count(err_count), .bit_count(bit_count)
   );

   lfsr_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .clear_cnt(clear_cnt), .locked(locked4), .bit_err(bit_err4),
      .err_count(err_count4), .bit_count(bit_count4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference generator: next bit is XNOR of taps 6 and 9, shifted into LSB.
   task automatic next_bit(output logic b);
      b = ~(g[6] ^ g[9]);
      g = {g[8:0], b};
   endtask

   task automatic send(input logic v, input logic b);
      in_valid = v;
      in_bit   = b;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      clear_cnt = 1'b0;
   endtask

   task automatic send_gen(input logic flip);
      logic b;
      next_bit(b);
      send(1'b1, b ^ flip);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      g = '0;
   endtask

   initial begin
      int   n;
      logic seen;

      // Reset state while reset is held low from time 0.
      #3;
      check("rst_locked", 32'(locked), 0);
      check("rst_bit_err", 32'(bit_err), 0);
      check("rst_err_count", 32'(err_count), 0);
      check("rst_bit_count", 32'(bit_count), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Test 1: clean stream, continuous valid.
      for (int i = 0; i < 25; i++) send_gen(1'b0);
      check("t1_not_locked_25", 32'(locked), 0);
      send_gen(1'b0);
      check("t1_locked_26", 32'(locked), 1);
      check("t1_bit_count_at_lock", 32'(bit_count), 0);
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         send_gen(1'b0);
         seen = seen | bit_err;
      end
      check("t1_bit_err_never", 32'(seen), 0);
      check("t1_err_count", 32'(err_count), 0);
      check("t1_bit_count", 32'(bit_count), 1000);

      // Test 2: valid toggling 1/0.
      do_reset();
      for (int i = 0; i < 25; i++) begin
         send_gen(1'b0);
         send(1'b0, 1'($urandom_range(0, 1)));
      end
      check("t2_not_locked_25", 32'(locked), 0);
      send_gen(1'b0);
      check("t2_locked_26", 32'(locked), 1);
      send(1'b0, 1'b1);
      check("t2_locked_idle", 32'(locked), 1);
      check("t2_bit_count_idle", 32'(bit_count), 0);
      for (int i = 0; i < 10; i++) begin
         send_gen(1'b0);
         send(1'b0, 1'($urandom_range(0, 1)));
      end
      check("t2_bit_count_10", 32'(bit_count), 10);
      check("t2_err_count", 32'(err_count), 0);

      // Test 3: single inverted bit while locked.
      clear_cnt = 1'b1;
      send(1'b0, 1'b0);
      check("t3_clear_bit_count", 32'(bit_count), 0);
      send_gen(1'b1);
      check("t3_bit_err_pulse", 32'(bit_err), 1);
      check("t3_err_count", 32'(err_count), 1);
      check("t3_locked", 32'(locked), 1);
      send(1'b0, 1'b0);
      check("t3_bit_err_clears_idle", 32'(bit_err), 0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         send_gen(1'b0);
         seen = seen | bit_err;
      end
      check("t3_no_more_err", 32'(seen), 0);
      check("t3_err_count_after", 32'(err_count), 1);
      check("t3_bit_count_after", 32'(bit_count), 51);

      // Test 4: four consecutive inverted bits unlock, then relock.
      clear_cnt = 1'b1;
      send(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_gen(1'b1);
      check("t4_locked_after_3", 32'(locked), 1);
      send_gen(1'b1);
      check("t4_unlocked_after_4", 32'(locked), 0);
      check("t4_err_count", 32'(err_count), 4);
      check("t4_bit_err_4th", 32'(bit_err), 1);
      for (int i = 0; i < 25; i++) send_gen(1'b0);
      check("t4_not_relocked_25", 32'(locked), 0);
      check("t4_counts_hold_hunt", 32'(bit_count), 4);
      send_gen(1'b0);
      check("t4_relocked_26", 32'(locked), 1);

      // Test 5a: all-ones stream never locks.
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         send(1'b1, 1'b1);
         seen = seen | locked;
      end
      check("t5_ones_never_lock", 32'(seen), 0);

      // Test 5b: asynchronous reset while locked.
      do_reset();
      for (int i = 0; i < 30; i++) send_gen(1'b0);
      send_gen(1'b1);
      check("t5_pre_locked", 32'(locked), 1);
      check("t5_pre_bit_err", 32'(bit_err), 1);
      #2;
      reset = 1'b0;
      #1;
      check("t5_async_locked", 32'(locked), 0);
      check("t5_async_bit_err", 32'(bit_err), 0);
      check("t5_async_err_count", 32'(err_count), 0);
      check("t5_async_bit_count", 32'(bit_count), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      g = '0;

      // Test 6: narrow counter saturation and clear priority.
      for (int i = 0; i < 26; i++) send_gen(1'b0);
      check("t6_locked", 32'(locked4), 1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         send_gen(1'b1);
         n++;
         send_gen(1'b0);
         send_gen(1'b0);
      end
      check("t6_err_sat_15", 32'(err_count4), 15);
      check("t6_bit_sat_15", 32'(bit_count4), 15);
      check("t6_wide_err_20", 32'(err_count), 32'(n));
      check("t6_still_locked", 32'(locked4), 1);
      clear_cnt = 1'b1;
      send_gen(1'b1);
      check("t6_clear_err_count", 32'(err_count4), 0);
      check("t6_clear_bit_count", 32'(bit_count4), 0);
      check("t6_clear_bit_err", 32'(bit_err4), 1);
      check("t6_clear_wide_err", 32'(err_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against a stuck simulation.
   initial begin
      #500000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
